// File: rtl/nios_cpu_mult_pipe.sv
// nios_cpu_mult_pipe: two-stage W x W multiplier built from four H x H unsigned partial products.
// Define NIOS_CPU_MULT_HI_EN for the high word and signed (mulx*) forms; otherwise only the low word.
module nios_cpu_mult_pipe #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         a_signed,
    input  logic         b_signed,
    input  logic         sel_hi,
    output logic         out_valid,
    output logic [W-1:0] result
);
    localparam int unsigned H = W / 2;

    logic [W-1:0] pp_ll_d, pp_lh_d, pp_hl_d;
    logic [W-1:0] pp_ll, pp_lh, pp_hl;
    logic [W-1:0] result_d;
    logic         v1;

`ifdef NIOS_CPU_MULT_HI_EN
    logic [W-1:0]   pp_hh_d, pp_hh;
    logic [W-1:0]   corr_a, corr_b;
    logic           sel_hi_r;
    logic [2*W-1:0] p_full;
`else
    logic           unused_cfg;
    assign unused_cfg = ^{a_signed, b_signed, sel_hi};
`endif

    always_comb begin
        pp_ll_d = {{H{1'b0}}, a[H-1:0]} * {{H{1'b0}}, b[H-1:0]};
        pp_lh_d = {{H{1'b0}}, a[H-1:0]} * {{H{1'b0}}, b[W-1:H]};
        pp_hl_d = {{H{1'b0}}, a[W-1:H]} * {{H{1'b0}}, b[H-1:0]};
`ifdef NIOS_CPU_MULT_HI_EN
        pp_hh_d = {{H{1'b0}}, a[W-1:H]} * {{H{1'b0}}, b[W-1:H]};
`endif
    end

    // Data registers load on every enabled cycle; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (reset) begin
            pp_ll  <= '0;
            pp_lh  <= '0;
            pp_hl  <= '0;
            result <= '0;
`ifdef NIOS_CPU_MULT_HI_EN
            pp_hh    <= '0;
            corr_a   <= '0;
            corr_b   <= '0;
            sel_hi_r <= 1'b0;
`endif
        end else if (en) begin
            pp_ll  <= pp_ll_d;
            pp_lh  <= pp_lh_d;
            pp_hl  <= pp_hl_d;
            result <= result_d;
`ifdef NIOS_CPU_MULT_HI_EN
            pp_hh    <= pp_hh_d;
            corr_a   <= (a_signed & a[W-1]) ? b : '0;
            corr_b   <= (b_signed & b[W-1]) ? a : '0;
            sel_hi_r <= sel_hi;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            out_valid <= v1;
        end
    end

    // Signed operands: subtract the other operand at weight 2^W for each negative input (mod 2^2W).
    always_comb begin
`ifdef NIOS_CPU_MULT_HI_EN
        p_full = {{W{1'b0}}, pp_ll}
               + ({{W{1'b0}}, pp_lh} << H)
               + ({{W{1'b0}}, pp_hl} << H)
               + {pp_hh, {W{1'b0}}}
               - {corr_a, {W{1'b0}}}
               - {corr_b, {W{1'b0}}};
        result_d = sel_hi_r ? p_full[2*W-1:W] : p_full[W-1:0];
`else
        result_d = pp_ll + ((pp_lh + pp_hl) << H);
`endif
    end

endmodule
